// File: rtl/mult_err_monitor.sv
// mult_err_monitor: error-statistics monitor for approximate 8x8 multipliers.
// Each accepted sample (A, B, R) is compared with the exact product A*B.
// Over a programmed window of WINDOW samples the block accumulates the
// sample count, the erroneous-sample count, the sum of error distance
// ED = |A*B - R|, and the worst ED together with the operands that caused it.
//
// Optional build macro MULT_ERR_MON_SQ_EN adds ed_sq_sum (sum of ED*ED) and
// a third pipeline stage for the squarer.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              pulse, begins a run from IDLE or DONE
//   clear              synchronous abort to IDLE, zeroes stats, flushes pipe
//   in_valid/in_ready  sample handshake (in_ready high only in RUN)
//   A, B, R            operands and approximate product under test
//   busy, done         RUN/DRAIN and DONE indicators
//   sample_cnt         samples accepted in the current run
//   err_cnt            samples with ED != 0
//   ed_sum             sum of ED
//   ed_sq_sum          sum of ED*ED (MULT_ERR_MON_SQ_EN only)
//   ed_max             largest ED seen
//   max_a, max_b       operands of the first sample reaching ed_max
module mult_err_monitor #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SUM_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        A,
  input  logic [7:0]        B,
  input  logic [15:0]       R,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  ed_sum,
`ifdef MULT_ERR_MON_SQ_EN
  output logic [SUM_W+15:0] ed_sq_sum,
`endif
  output logic [15:0]       ed_max,
  output logic [7:0]        max_a,
  output logic [7:0]        max_b
);

  // Elaboration-time parameter legality
  if (WINDOW == 0 || 64'(WINDOW) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_window
    $error("mult_err_monitor: WINDOW out of range 1..2^CNT_W-1");
  end
  if (SUM_W < 16 + CNT_W) begin : g_bad_sum_w
    $error("mult_err_monitor: SUM_W must be >= 16+CNT_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic accept_c;
  logic zero_c;
  logic drain_done_c;

  // Stage 1: operands and exact product
  logic        s1_valid;
  logic [7:0]  s1_a, s1_b;
  logic [15:0] s1_r, s1_p;

  // Stage 2: error distance
  logic        s2_valid;
  logic [7:0]  s2_a, s2_b;
  logic [15:0] s2_ed;

  // View of whichever stage feeds the statistics
  logic        last_valid;
  logic [7:0]  last_a, last_b;
  logic [15:0] last_ed;

  assign accept_c = in_valid && in_ready;

`ifdef MULT_ERR_MON_SQ_EN
  // Stage 3: squared error distance
  logic        s3_valid;
  logic [7:0]  s3_a, s3_b;
  logic [15:0] s3_ed;
  logic [31:0] s3_sq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_a     <= '0;
      s3_b     <= '0;
      s3_ed    <= '0;
      s3_sq    <= '0;
    end else begin
      s3_valid <= s2_valid && !clear;
      s3_a     <= s2_a;
      s3_b     <= s2_b;
      s3_ed    <= s2_ed;
      s3_sq    <= 32'(s2_ed) * 32'(s2_ed);
    end
  end

  assign last_valid   = s3_valid;
  assign last_a       = s3_a;
  assign last_b       = s3_b;
  assign last_ed      = s3_ed;
  // Only the final stage may still hold a sample when DRAIN ends
  assign drain_done_c = !s1_valid && !s2_valid;
`else
  assign last_valid   = s2_valid;
  assign last_a       = s2_a;
  assign last_b       = s2_b;
  assign last_ed      = s2_ed;
  assign drain_done_c = !s1_valid;
`endif

  // Pipeline stages 1 and 2; clear drops any in-flight sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_r     <= '0;
      s1_p     <= '0;
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_ed    <= '0;
    end else begin
      s1_valid <= accept_c && !clear;
      if (accept_c) begin
        s1_a <= A;
        s1_b <= B;
        s1_r <= R;
        s1_p <= 16'(16'(A) * 16'(B));
      end
      s2_valid <= s1_valid && !clear;
      s2_a     <= s1_a;
      s2_b     <= s1_b;
      s2_ed    <= (s1_p >= s1_r) ? (s1_p - s1_r) : (s1_r - s1_p);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    next_state = state;
    zero_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_RUN;
          zero_c     = 1'b1;
        end
      end
      S_RUN: begin
        if (accept_c && sample_cnt == CNT_W'(WINDOW - 1)) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done_c) next_state = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          next_state = S_RUN;
          zero_c     = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (clear) begin
      next_state = S_IDLE;
      zero_c     = 1'b1;
    end
  end

  // Status outputs registered from the next state so they track the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (next_state == S_RUN);
      busy     <= (next_state == S_RUN) || (next_state == S_DRAIN);
      done     <= (next_state == S_DONE);
    end
  end

  // Statistics accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
`ifdef MULT_ERR_MON_SQ_EN
      ed_sq_sum  <= '0;
`endif
      ed_max     <= '0;
      max_a      <= '0;
      max_b      <= '0;
    end else if (zero_c) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
`ifdef MULT_ERR_MON_SQ_EN
      ed_sq_sum  <= '0;
`endif
      ed_max     <= '0;
      max_a      <= '0;
      max_b      <= '0;
    end else begin
      if (accept_c) sample_cnt <= sample_cnt + CNT_W'(1);
      if (last_valid) begin
        if (last_ed != 16'd0) err_cnt <= err_cnt + CNT_W'(1);
        ed_sum <= ed_sum + SUM_W'(last_ed);
`ifdef MULT_ERR_MON_SQ_EN
        ed_sq_sum <= ed_sq_sum + (SUM_W + 16)'(s3_sq);
`endif
        // Strict compare: ties keep the earlier sample's operands
        if (last_ed > ed_max) begin
          ed_max <= last_ed;
          max_a  <= last_a;
          max_b  <= last_b;
        end
      end
    end
  end

endmodule
